pinlv_gen: RTL and testbench

Programmable two-channel square-wave generator: the stimulus side of the frequency/phase measurement chain. Produces `sig_out` with a configured period and high time, plus `sig_out1` with the same waveform delayed by a configured phase. It drives the measurement block's `sig_in`/`sig_in1` in loopback tests and on the board. Configuration is accepted through a valid/ready handshake and applied glitch-free at period boundaries.

---
 rtl/pinlv_gen.sv | 157 +++++++++++++++
 tb/tb_pinlv_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pinlv_gen.sv
// Two-channel programmable square-wave generator with a validated, glitch-free
// config handshake. Channel 1 is channel 0 delayed by a configurable phase.
module pinlv_gen #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_phase,
    output logic             cfg_err,
    output logic             sig_out,
    output logic             sig_out1,
    output logic             period_tick
);

    localparam logic [CNT_W-1:0] Zero = '0;
    localparam logic [CNT_W-1:0] One  = CNT_W'(1);
    localparam logic [CNT_W-1:0] Two  = CNT_W'(2);

    typedef enum logic {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] per_q, per_d, hi_q, hi_d, ph_q, ph_d;
    logic [CNT_W-1:0] pper_q, pper_d, phi_q, phi_d, pph_q, pph_d;
    logic             pend_q, pend_d, loaded_q, loaded_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt1_q, cnt1_d;
    logic             sig_q, sig_d, sig1_q, sig1_d, tick_q, tick_d, err_q, err_d;

    logic             xfer, cfg_legal, wrap, swap;
    logic [CNT_W-1:0] phase_init, cnt1_inc;

    // Handshake, validation, config swap, counters and registered outputs.
    always_comb begin
        state_d  = state_q;
        per_d    = per_q;
        hi_d     = hi_q;
        ph_d     = ph_q;
        pper_d   = pper_q;
        phi_d    = phi_q;
        pph_d    = pph_q;
        pend_d   = pend_q;
        loaded_d = loaded_q;
        cnt_d    = cnt_q;
        cnt1_d   = cnt1_q;
        err_d    = 1'b0;

        xfer      = cfg_valid && !pend_q;
        cfg_legal = (cfg_period >= Two) && (cfg_high >= One) && (cfg_high < cfg_period) &&
                    (cfg_phase < cfg_period);
        wrap      = (state_q == StRun) && (cnt_q == per_q - One);
        swap      = pend_q && ((state_q == StIdle) || wrap);

        if (xfer) begin
            if (cfg_legal) begin
                pper_d = cfg_period;
                phi_d  = cfg_high;
                pph_d  = cfg_phase;
                pend_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        // xfer needs !pend_q and swap needs pend_q, so the two never collide.
        if (swap) begin
            per_d    = pper_q;
            hi_d     = phi_q;
            ph_d     = pph_q;
            pend_d   = 1'b0;
            loaded_d = 1'b1;
        end

        // Channel-1 start value (per - ph) mod per; ph < per always holds.
        phase_init = (ph_d == Zero) ? Zero : (per_d - ph_d);
        cnt1_inc   = (cnt1_q == per_q - One) ? Zero : (cnt1_q + One);

        unique case (state_q)
            StIdle: begin
                cnt_d  = Zero;
                cnt1_d = Zero;
                if (en && loaded_q) begin
                    state_d = StRun;
                    cnt1_d  = phase_init;
                end
            end
            StRun: begin
                if (wrap) begin
                    cnt_d = Zero;
                    if (!en) begin
                        state_d = StIdle;
                        cnt1_d  = Zero;
                    end else if (swap) begin
                        cnt1_d = phase_init;
                    end else begin
                        cnt1_d = cnt1_inc;
                    end
                end else begin
                    cnt_d  = cnt_q + One;
                    cnt1_d = cnt1_inc;
                end
            end
            default: state_d = StIdle;
        endcase

        sig_d  = (state_d == StRun) && (cnt_d < hi_d);
        sig1_d = (state_d == StRun) && (cnt1_d < hi_d);
        tick_d = (state_d == StRun) && (cnt_d == Zero);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q  <= StIdle;
            per_q    <= '0;
            hi_q     <= '0;
            ph_q     <= '0;
            pper_q   <= '0;
            phi_q    <= '0;
            pph_q    <= '0;
            pend_q   <= 1'b0;
            loaded_q <= 1'b0;
            cnt_q    <= '0;
            cnt1_q   <= '0;
            sig_q    <= 1'b0;
            sig1_q   <= 1'b0;
            tick_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            per_q    <= per_d;
            hi_q     <= hi_d;
            ph_q     <= ph_d;
            pper_q   <= pper_d;
            phi_q    <= phi_d;
            pph_q    <= pph_d;
            pend_q   <= pend_d;
            loaded_q <= loaded_d;
            cnt_q    <= cnt_d;
            cnt1_q   <= cnt1_d;
            sig_q    <= sig_d;
            sig1_q   <= sig1_d;
            tick_q   <= tick_d;
            err_q    <= err_d;
        end
    end

    assign cfg_ready   = !pend_q;
    assign cfg_err     = err_q;
    assign sig_out     = sig_q;
    assign sig_out1    = sig1_q;
    assign period_tick = tick_q;

endmodule

// File: tb/tb_pinlv_gen.sv
// Self-checking bench for pinlv_gen: vector table, directed sequences and
// randomized traffic against a position-based reference model.
module tb_pinlv_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_period = '0;
    logic [31:0] cfg_high = '0;
    logic [31:0] cfg_phase = '0;
    logic        cfg_err, sig_out, sig_out1, period_tick;

    int checks = 0;
    int errors = 0;

    // Reference model: running flag, position within period, config sets.
    bit          m_run, m_pend, m_loaded, m_err;
    int unsigned m_pos, m_per, m_hi, m_ph, p_per, p_hi, p_ph;

    typedef struct {
        int unsigned p;
        int unsigned h;
        int unsigned ph;
        bit          err;
    } vec_t;
    vec_t tbl[9];

    pinlv_gen #(.CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
        .cfg_phase   (cfg_phase),
        .cfg_err     (cfg_err),
        .sig_out     (sig_out),
        .sig_out1    (sig_out1),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, step the model on the edge, compare #1 later.
    task automatic cyc(input bit e, input bit v, input int unsigned p, input int unsigned h,
                       input int unsigned ph);
        bit          xfer, legal, last, swap, run_n, e_sig, e_sig1, e_tick;
        int unsigned pos_n;
        en = e; cfg_valid = v; cfg_period = p; cfg_high = h; cfg_phase = ph;
        @(posedge clk);
        if (rst_n) begin
            m_run = 0; m_pend = 0; m_loaded = 0; m_err = 0; m_pos = 0;
            m_per = 0; m_hi = 0; m_ph = 0; p_per = 0; p_hi = 0; p_ph = 0;
        end else begin
            xfer  = v && !m_pend;
            legal = (p >= 2) && (h >= 1) && (h < p) && (ph < p);
            last  = m_run && (m_pos == m_per - 1);
            swap  = m_pend && (!m_run || last);
            if (!m_run) begin
                run_n = e && m_loaded; pos_n = 0;
            end else if (last) begin
                run_n = e; pos_n = 0;
            end else begin
                run_n = 1; pos_n = m_pos + 1;
            end
            m_err = xfer && !legal;
            if (xfer && legal) begin
                m_pend = 1; p_per = p; p_hi = h; p_ph = ph;
            end
            if (swap) begin
                m_per = p_per; m_hi = p_hi; m_ph = p_ph; m_pend = 0; m_loaded = 1;
            end
            m_run = run_n;
            m_pos = pos_n;
        end
        e_sig  = m_run && (m_pos < m_hi);
        e_sig1 = m_run && (((m_pos + m_per - m_ph) % m_per) < m_hi);
        e_tick = m_run && (m_pos == 0);
        #1;
        chk("model_sig_out", sig_out, e_sig);
        chk("model_sig_out1", sig_out1, e_sig1);
        chk("model_period_tick", period_tick, e_tick);
        chk("model_cfg_err", cfg_err, m_err);
        chk("model_cfg_ready", cfg_ready, !m_pend);
    endtask

    task automatic idle1(input bit e);
        cyc(e, 0, 0, 0, 0);
    endtask

    // Run with en=1 until a period_tick (optionally with cfg_ready=1); bounded.
    task automatic wait_tick(input bit need_ready, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            idle1(1);
            if (period_tick === 1'b1 && (!need_ready || cfg_ready === 1'b1)) begin
                ok = 1;
                break;
            end
        end
        chk("tick_wait", ok, 1);
    endtask

    initial begin
        tbl[0] = '{p: 1,  h: 1,  ph: 0,  err: 1};
        tbl[1] = '{p: 10, h: 0,  ph: 0,  err: 1};
        tbl[2] = '{p: 10, h: 10, ph: 0,  err: 1};
        tbl[3] = '{p: 10, h: 3,  ph: 10, err: 1};
        tbl[4] = '{p: 0,  h: 0,  ph: 0,  err: 1};
        tbl[5] = '{p: 2,  h: 1,  ph: 1,  err: 0};
        tbl[6] = '{p: 3,  h: 3,  ph: 0,  err: 1};
        tbl[7] = '{p: 10, h: 9,  ph: 9,  err: 0};
        tbl[8] = '{p: 5,  h: 4,  ph: 0,  err: 0};

        // Reset state.
        rst_n = 1;
        idle1(0);
        idle1(0);
        chk("rst_sig_out", sig_out, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        rst_n = 0;

        // Validation table, applied in IDLE with en=0.
        foreach (tbl[k]) begin
            cyc(0, 1, tbl[k].p, tbl[k].h, tbl[k].ph);
            chk("tbl_err", cfg_err, tbl[k].err);
            chk("tbl_ready", cfg_ready, tbl[k].err);
            idle1(0);
            chk("tbl_err_clear", cfg_err, 0);
            chk("tbl_ready_back", cfg_ready, 1);
            chk("tbl_idle_out", sig_out, 0);
        end

        // (10,3,0): 1110000000 pattern, channel 1 identical.
        cyc(1, 1, 10, 3, 0);
        wait_tick(0, 10);
        for (int i = 0; i < 20; i++) begin
            if (i > 0) idle1(1);
            chk("p10_sig", sig_out, (i % 10) < 3);
            chk("p10_tick", period_tick, (i % 10) == 0);
            chk("p10_sig1", sig_out1, (i % 10) < 3);
        end

        // (8,4,3) then (8,4,7).
        cyc(1, 1, 8, 4, 3);
        wait_tick(1, 40);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) idle1(1);
            chk("ph3_sig", sig_out, (i % 8) < 4);
            chk("ph3_sig1", sig_out1, ((i + 5) % 8) < 4);
        end
        cyc(1, 1, 8, 4, 7);
        wait_tick(1, 40);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) idle1(1);
            chk("ph7_sig1", sig_out1, ((i + 1) % 8) < 4);
        end

        // Back to (10,3,0); illegal offers while running.
        cyc(1, 1, 10, 3, 0);
        wait_tick(1, 40);
        cyc(1, 1, 1, 1, 0);   chk("ill_run_err", cfg_err, 1); chk("ill_run_rdy", cfg_ready, 1);
        cyc(1, 1, 10, 0, 0);  chk("ill_run_err", cfg_err, 1); chk("ill_run_rdy", cfg_ready, 1);
        cyc(1, 1, 10, 10, 0); chk("ill_run_err", cfg_err, 1); chk("ill_run_rdy", cfg_ready, 1);
        cyc(1, 1, 10, 3, 10); chk("ill_run_err", cfg_err, 1); chk("ill_run_rdy", cfg_ready, 1);
        idle1(1);             chk("ill_run_err_clr", cfg_err, 0);

        // Offer (6,2,1) at cnt=4: old period completes, then new pattern.
        wait_tick(0, 12);
        for (int i = 0; i < 4; i++) idle1(1);
        cyc(1, 1, 6, 2, 1);
        chk("swap_ready_low", cfg_ready, 0);
        for (int i = 0; i < 4; i++) begin
            idle1(1);
            chk("swap_old_sig", sig_out, 0);
            chk("swap_old_tick", period_tick, 0);
            chk("swap_ready_low2", cfg_ready, 0);
        end
        idle1(1);
        chk("swap_new_tick", period_tick, 1);
        chk("swap_ready_back", cfg_ready, 1);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) idle1(1);
            chk("p6_sig", sig_out, (i % 6) < 2);
            chk("p6_sig1", sig_out1, ((i + 5) % 6) < 2);
        end

        // (10,5,0): drop en at cnt=2, period completes, then IDLE; restart.
        cyc(1, 1, 10, 5, 0);
        wait_tick(1, 40);
        idle1(1);
        idle1(1);
        for (int c = 3; c < 10; c++) begin
            idle1(0);
            chk("stop_sig", sig_out, c < 5);
            chk("stop_tick", period_tick, 0);
        end
        idle1(0);
        chk("stopped_sig", sig_out, 0);
        chk("stopped_sig1", sig_out1, 0);
        chk("stopped_tick", period_tick, 0);
        idle1(0);
        chk("stopped_sig_b", sig_out, 0);
        idle1(1);
        chk("restart_tick", period_tick, 1);
        chk("restart_sig", sig_out, 1);

        // Reset mid-period with a pending config.
        idle1(1);
        cyc(1, 1, 6, 2, 1);
        chk("pend_ready_low", cfg_ready, 0);
        rst_n = 1;
        idle1(1);
        chk("mid_rst_sig", sig_out, 0);
        chk("mid_rst_sig1", sig_out1, 0);
        chk("mid_rst_ready", cfg_ready, 1);
        rst_n = 0;
        for (int i = 0; i < 5; i++) begin
            idle1(1);
            chk("unloaded_sig", sig_out, 0);
            chk("unloaded_tick", period_tick, 0);
        end
        cyc(1, 1, 10, 3, 0);
        wait_tick(1, 10);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) == 0);
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 12), $urandom_range(0, 13), $urandom_range(0, 13));
        end
        rst_n = 0;
        idle1(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
